// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between a fetch port and a data port.
// Define MEM_ARB_ROUND_ROBIN_EN to replace data priority and the starvation limit with round-robin.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ireq_valid,
  input  logic [31:0] ireq_address,
  output logic        ireq_ready,
  output logic        iresp_valid,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic        dreq_we,
  input  logic [31:0] dreq_address,
  input  logic [3:0]  dreq_byte_enable,
  input  logic [31:0] dreq_write,
  output logic        dreq_ready,
  output logic        dresp_valid,
  output logic [31:0] dresp_data,
  output logic [31:0] memory_address,
  output logic [31:0] memory_write,
  output logic [3:0]  memory_byte_enable,
  output logic        memory_we,
  input  logic [31:0] memory_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        tag_data_q;
  logic [2:0]  lat_cnt;
  logic        arb_en, grant_d, grant_i, accept;
  logic        unused_addr_bits;

  assign unused_addr_bits = &ireq_address[1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept)
        lat_cnt <= LAT_LOAD;
      else if (state == ACCESS && lat_cnt != 3'd0)
        lat_cnt <= lat_cnt - 3'd1;
    end
  end

  // NOTE: defaults first so every path assigns state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  if (lat_cnt == 3'd0) state_next = RESP;
      RESP:    state_next = accept ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Arbitration is only open between accesses; outputs are forced low while reset is held.
  assign arb_en     = rst_n && (state == IDLE || state == RESP);
  assign grant_i    = ireq_valid && !grant_d;
  assign ireq_ready = arb_en && grant_i;
  assign dreq_ready = arb_en && grant_d;
  assign accept     = ireq_ready || dreq_ready;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_data_q;

  always_comb begin
    if (ireq_valid && dreq_valid)
      grant_d = !last_data_q;
    else
      grant_d = dreq_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_data_q <= 1'b0;
    else if (accept)
      last_data_q <= dreq_ready;
  end
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign grant_d = dreq_valid && !(ireq_valid && starve_cnt == STARVE_MAX);

  // Counts data grants that bypassed a waiting fetch; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (accept) begin
      if (ireq_ready || !ireq_valid)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // Payload is captured only on the accept edge; write data holds across fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      tag_data_q <= 1'b0;
    end else if (dreq_ready) begin
      addr_q     <= dreq_address;
      wdata_q    <= dreq_write;
      be_q       <= dreq_byte_enable;
      we_q       <= dreq_we;
      tag_data_q <= 1'b1;
    end else if (ireq_ready) begin
      addr_q     <= {ireq_address[31:2], 2'b00};
      be_q       <= 4'b1111;
      we_q       <= 1'b0;
      tag_data_q <= 1'b0;
    end
  end

  // The first ACCESS cycle is the one still holding the freshly loaded count.
  assign memory_address     = addr_q;
  assign memory_write       = wdata_q;
  assign memory_byte_enable = (state == ACCESS) ? be_q : 4'b0000;
  assign memory_we          = (state == ACCESS) && (lat_cnt == LAT_LOAD) && we_q;

  assign iresp_valid = (state == RESP) && !tag_data_q;
  assign dresp_valid = (state == RESP) && tag_data_q;
  assign iresp_data  = iresp_valid ? memory_out : 32'h0;
  assign dresp_data  = (dresp_valid && !we_q) ? memory_out : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3,
// each backed by a small byte-enabled memory model with the matching read latency.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  // Instance 1: MEM_LATENCY = 1
  logic        ireq_valid, ireq_ready, iresp_valid;
  logic [31:0] ireq_address, iresp_data;
  logic        dreq_valid, dreq_we, dreq_ready, dresp_valid;
  logic [31:0] dreq_address, dreq_write, dresp_data;
  logic [3:0]  dreq_byte_enable, memory_byte_enable;
  logic [31:0] memory_address, memory_write, memory_out;
  logic        memory_we;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ireq_valid(ireq_valid), .ireq_address(ireq_address), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_address(dreq_address),
    .dreq_byte_enable(dreq_byte_enable), .dreq_write(dreq_write), .dreq_ready(dreq_ready),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .memory_address(memory_address), .memory_write(memory_write),
    .memory_byte_enable(memory_byte_enable), .memory_we(memory_we), .memory_out(memory_out)
  );

  // Instance 2: MEM_LATENCY = 3
  logic        l3_ireq_valid, l3_ireq_ready, l3_iresp_valid;
  logic [31:0] l3_ireq_address, l3_iresp_data;
  logic        l3_dreq_valid, l3_dreq_we, l3_dreq_ready, l3_dresp_valid;
  logic [31:0] l3_dreq_address, l3_dreq_write, l3_dresp_data;
  logic [3:0]  l3_dreq_byte_enable, l3_memory_byte_enable;
  logic [31:0] l3_memory_address, l3_memory_write, l3_memory_out;
  logic        l3_memory_we;

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .ireq_valid(l3_ireq_valid), .ireq_address(l3_ireq_address), .ireq_ready(l3_ireq_ready),
    .iresp_valid(l3_iresp_valid), .iresp_data(l3_iresp_data),
    .dreq_valid(l3_dreq_valid), .dreq_we(l3_dreq_we), .dreq_address(l3_dreq_address),
    .dreq_byte_enable(l3_dreq_byte_enable), .dreq_write(l3_dreq_write), .dreq_ready(l3_dreq_ready),
    .dresp_valid(l3_dresp_valid), .dresp_data(l3_dresp_data),
    .memory_address(l3_memory_address), .memory_write(l3_memory_write),
    .memory_byte_enable(l3_memory_byte_enable), .memory_we(l3_memory_we), .memory_out(l3_memory_out)
  );

  // Memory models: preloaded while reset is held (word 4 = 0x13), synchronous byte writes.
  logic [31:0] mem1 [64];
  logic [31:0] rd1;
  logic [31:0] mem3 [64];
  logic [31:0] rd3_a, rd3_b, rd3_c;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < 64; w++) mem1[w] <= 32'h0;
      mem1[4] <= 32'h0000_0013;
    end else if (memory_we) begin
      for (int b = 0; b < 4; b++)
        if (memory_byte_enable[b]) mem1[memory_address[7:2]][8*b +: 8] <= memory_write[8*b +: 8];
    end
    rd1 <= mem1[memory_address[7:2]];
  end
  assign memory_out = rd1;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < 64; w++) mem3[w] <= 32'h0;
    end else if (l3_memory_we) begin
      for (int b = 0; b < 4; b++)
        if (l3_memory_byte_enable[b]) mem3[l3_memory_address[7:2]][8*b +: 8] <= l3_memory_write[8*b +: 8];
    end
    rd3_a <= mem3[l3_memory_address[7:2]];
    rd3_b <= rd3_a;
    rd3_c <= rd3_b;
  end
  assign l3_memory_out = rd3_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic [9:0] EXP_SEQ = 10'b0101010101;  // bit n set = grant n goes to data
`else
  localparam logic [9:0] EXP_SEQ = 10'b0111101111;
`endif

  function automatic logic [136:0] outs1();
    return {ireq_ready, iresp_valid, iresp_data, dreq_ready, dresp_valid, dresp_data,
            memory_address, memory_write, memory_byte_enable, memory_we};
  endfunction

  function automatic logic [136:0] outs3();
    return {l3_ireq_ready, l3_iresp_valid, l3_iresp_data, l3_dreq_ready, l3_dresp_valid, l3_dresp_data,
            l3_memory_address, l3_memory_write, l3_memory_byte_enable, l3_memory_we};
  endfunction

  task automatic test_reset();
    ireq_valid = 1'b1;
    l3_dreq_valid = 1'b1;
    #1;
    tests_run++;
    if (outs1() !== '0) begin
      tests_failed++; $display("FAIL reset_outs got %h exp 0", outs1());
    end
    tests_run++;
    if (outs3() !== '0) begin
      tests_failed++; $display("FAIL reset_outs_l3 got %h exp 0", outs3());
    end
    ireq_valid = 1'b0;
    l3_dreq_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (outs1() !== '0) begin
      tests_failed++; $display("FAIL idle_after_reset got %h exp 0", outs1());
    end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    ireq_valid = 1'b1; ireq_address = 32'h12;
    #1;
    tests_run++;
    if ({ireq_ready, dreq_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL fetch_ready got %b exp 10", {ireq_ready, dreq_ready});
    end
    @(negedge clk);
    ireq_valid = 1'b0;
    #1;
    tests_run++;
    if ({ireq_ready, memory_we, memory_byte_enable, memory_address} !== {2'b00, 4'b1111, 32'h10}) begin
      tests_failed++;
      $display("FAIL fetch_access got rdy=%b we=%b be=%b addr=%h exp 0 0 1111 00000010",
               ireq_ready, memory_we, memory_byte_enable, memory_address);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({iresp_valid, dresp_valid, iresp_data} !== {2'b10, 32'h13}) begin
      tests_failed++;
      $display("FAIL fetch_resp got iv=%b dv=%b data=%h exp 1 0 00000013", iresp_valid, dresp_valid, iresp_data);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({iresp_valid, memory_byte_enable} !== 5'b0) begin
      tests_failed++; $display("FAIL fetch_pulse got iv=%b be=%b exp 0 0000", iresp_valid, memory_byte_enable);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    dreq_valid = 1'b1; dreq_we = 1'b1; dreq_address = 32'h22;
    dreq_byte_enable = 4'b0100; dreq_write = 32'h00AB_0000;
    #1;
    tests_run++;
    if ({ireq_ready, dreq_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL write_ready got %b exp 01", {ireq_ready, dreq_ready});
    end
    @(negedge clk);
    dreq_valid = 1'b0;
    #1;
    tests_run++;
    if ({memory_we, memory_byte_enable, memory_write, memory_address} !== {1'b1, 4'b0100, 32'h00AB_0000, 32'h22}) begin
      tests_failed++;
      $display("FAIL write_access got we=%b be=%b wd=%h addr=%h exp 1 0100 00ab0000 00000022",
               memory_we, memory_byte_enable, memory_write, memory_address);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({memory_we, dresp_valid, iresp_valid, dresp_data} !== {3'b010, 32'h0}) begin
      tests_failed++;
      $display("FAIL write_resp got we=%b dv=%b iv=%b data=%h exp 0 1 0 00000000",
               memory_we, dresp_valid, iresp_valid, dresp_data);
    end
    @(negedge clk);
    dreq_valid = 1'b1; dreq_we = 1'b0; dreq_address = 32'h20; dreq_byte_enable = 4'b1111;
    #1;
    tests_run++;
    if (dreq_ready !== 1'b1) begin
      tests_failed++; $display("FAIL read_ready got %b exp 1", dreq_ready);
    end
    @(negedge clk);
    dreq_valid = 1'b0;
    #1;
    tests_run++;
    if ({memory_we, memory_byte_enable} !== 5'b01111) begin
      tests_failed++; $display("FAIL read_access got we=%b be=%b exp 0 1111", memory_we, memory_byte_enable);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({dresp_valid, dresp_data} !== {1'b1, 32'h00AB_0000}) begin
      tests_failed++; $display("FAIL read_back got dv=%b data=%h exp 1 00ab0000", dresp_valid, dresp_data);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int last_cyc = 0;
    logic prev_d = 1'b0;
    logic [1:0] exp_g;
    @(negedge clk);
    ireq_valid = 1'b1; ireq_address = 32'h10;
    #1;
    tests_run++;
    if ({ireq_ready, dreq_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL b2b_seed got %b exp 10", {ireq_ready, dreq_ready});
    end
    for (int cyc = 1; cyc <= 40 && n < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        dreq_valid = 1'b1; dreq_we = 1'b0; dreq_address = 32'h20; dreq_byte_enable = 4'b1111;
      end
      #1;
      if (ireq_ready || dreq_ready) begin
        exp_g = EXP_SEQ[n] ? 2'b01 : 2'b10;
        tests_run++;
        if ({ireq_ready, dreq_ready} !== exp_g) begin
          tests_failed++; $display("FAIL b2b_grant%0d got %b exp %b", n, {ireq_ready, dreq_ready}, exp_g);
        end
        tests_run++;
        if ({iresp_valid, dresp_valid} !== (prev_d ? 2'b01 : 2'b10)) begin
          tests_failed++;
          $display("FAIL b2b_resp%0d got %b exp %b", n, {iresp_valid, dresp_valid}, prev_d ? 2'b01 : 2'b10);
        end
        tests_run++;
        if (cyc - last_cyc != 2) begin
          tests_failed++; $display("FAIL b2b_gap%0d got %0d exp 2", n, cyc - last_cyc);
        end
        prev_d = dreq_ready;
        last_cyc = cyc;
        n++;
      end
    end
    tests_run++;
    if (n != 10) begin
      tests_failed++; $display("FAIL b2b_timeout got %0d grants exp 10", n);
    end
    @(negedge clk);
    ireq_valid = 1'b0; dreq_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency3();
    @(negedge clk);
    l3_dreq_valid = 1'b1; l3_dreq_we = 1'b1; l3_dreq_address = 32'h8;
    l3_dreq_byte_enable = 4'b1111; l3_dreq_write = 32'hCAFE_F00D;
    #1;
    tests_run++;
    if (l3_dreq_ready !== 1'b1) begin
      tests_failed++; $display("FAIL l3_accept got %b exp 1", l3_dreq_ready);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        l3_dreq_valid = 1'b0; l3_ireq_valid = 1'b1; l3_ireq_address = 32'h0;
      end
      #1;
      tests_run++;
      if ({l3_ireq_ready, l3_dreq_ready, l3_iresp_valid, l3_dresp_valid, l3_memory_we, l3_memory_byte_enable}
          !== {4'b0000, (k == 1), 4'b1111}) begin
        tests_failed++;
        $display("FAIL l3_access%0d got rdy=%b%b rv=%b%b we=%b be=%b exp 00 00 %0d 1111", k,
                 l3_ireq_ready, l3_dreq_ready, l3_iresp_valid, l3_dresp_valid, l3_memory_we,
                 l3_memory_byte_enable, (k == 1));
      end
    end
    @(negedge clk);
    l3_ireq_valid = 1'b0;
    #1;
    tests_run++;
    if ({l3_dresp_valid, l3_iresp_valid, l3_dresp_data, l3_memory_byte_enable} !== {2'b10, 32'h0, 4'b0}) begin
      tests_failed++;
      $display("FAIL l3_resp got dv=%b iv=%b data=%h be=%b exp 1 0 00000000 0000",
               l3_dresp_valid, l3_iresp_valid, l3_dresp_data, l3_memory_byte_enable);
    end
    @(negedge clk);
    l3_dreq_valid = 1'b1; l3_dreq_we = 1'b0;
    #1;
    tests_run++;
    if (l3_dreq_ready !== 1'b1) begin
      tests_failed++; $display("FAIL l3_read_accept got %b exp 1", l3_dreq_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      l3_dreq_valid = 1'b0;
      #1;
      tests_run++;
      if ({l3_dresp_valid, l3_dresp_data} !== ((k == 4) ? {1'b1, 32'hCAFE_F00D} : 33'h0)) begin
        tests_failed++; $display("FAIL l3_read%0d got dv=%b data=%h exp dv=%0d", k, l3_dresp_valid, l3_dresp_data, (k == 4));
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    ireq_valid = 1'b1; ireq_address = 32'h10;
    #1;
    tests_run++;
    if (ireq_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_accept got %b exp 1", ireq_ready);
    end
    @(negedge clk);
    ireq_valid = 1'b0;
    #1;
    tests_run++;
    if (memory_byte_enable !== 4'b1111) begin
      tests_failed++; $display("FAIL mid_inflight got be=%b exp 1111", memory_byte_enable);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (outs1() !== '0) begin
      tests_failed++; $display("FAIL mid_async_clear got %h exp 0", outs1());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++;
      if ({iresp_valid, dresp_valid, memory_byte_enable} !== 6'b0) begin
        tests_failed++;
        $display("FAIL mid_no_resp%0d got iv=%b dv=%b be=%b exp 0 0 0000", k, iresp_valid, dresp_valid, memory_byte_enable);
      end
      @(negedge clk);
    end
    ireq_valid = 1'b1; ireq_address = 32'h13;
    #1;
    tests_run++;
    if (ireq_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mid_reaccept got %b exp 1", ireq_ready);
    end
    @(negedge clk);
    ireq_valid = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if ({iresp_valid, iresp_data} !== {1'b1, 32'h13}) begin
      tests_failed++; $display("FAIL mid_refetch got iv=%b data=%h exp 1 00000013", iresp_valid, iresp_data);
    end
  endtask

  initial begin
    ireq_valid = 1'b0; ireq_address = '0;
    dreq_valid = 1'b0; dreq_we = 1'b0; dreq_address = '0; dreq_byte_enable = '0; dreq_write = '0;
    l3_ireq_valid = 1'b0; l3_ireq_address = '0;
    l3_dreq_valid = 1'b0; l3_dreq_we = 1'b0; l3_dreq_address = '0;
    l3_dreq_byte_enable = '0; l3_dreq_write = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_fetch();
    test_write_read();
    test_back_to_back();
    test_latency3();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters:
  - instruction fetch: read-only, word access;
  - memory_access stage: read/write, byte-enabled.
- Sits between the pipeline stages and the memory macro.
- Sequences each access through a fixed-latency memory: grant, address phase, wait, response.
- Data port has priority, bounded by a starvation limit for the fetch port.

Parameters:
- MEM_LATENCY, 1: cycles from address presented on memory_address to valid memory_out; legal range 1..7.
- STARVE_LIMIT, 4: max consecutive data grants while an instruction request is pending; legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ireq_valid  in  1  fetch request.
- ireq_address  in  32  fetch word address; bits [1:0] ignored and forced to 0 on memory_address.
- ireq_ready  out  1  fetch request accepted this cycle.
- iresp_valid  out  1  fetch read data valid, one-cycle pulse.
- iresp_data  out  32  fetch read data.
- dreq_valid  in  1  data request.
- dreq_we  in  1  1 = write, 0 = read.
- dreq_address  in  32  data byte address.
- dreq_byte_enable  in  4  lane enables, already shifted by requester.
- dreq_write  in  32  write data, already lane-aligned.
- dreq_ready  out  1  data request accepted this cycle.
- dresp_valid  out  1  data response (read data, or write ack), one-cycle pulse.
- dresp_data  out  32  raw memory_out word; 0 for writes.
- memory_address  out  32  to memory.
- memory_write  out  32  to memory.
- memory_byte_enable  out  4  to memory.
- memory_we  out  1  to memory.
- memory_out  in  32  from memory.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE; all outputs 0; starvation counter 0; RR pointer = instruction.
  - Any in-flight access is dropped; no response is produced after release.
- States: IDLE, ACCESS, RESP.
- Grant rule:
  - Arbitration happens only in IDLE or RESP.
  - Exactly one of ireq_ready/dreq_ready is high in a cycle where the winning requester has valid=1; the other stays low.
  - Both ready are low in ACCESS.
- Accept cycle T:
  - Register the winner's address, write data, byte enable, we and a port tag.
  - Fetch requests register byte_enable=4'b1111, we=0.
  - Go to ACCESS.
- ACCESS (cycles T+1 .. T+MEM_LATENCY):
  - memory_address, memory_write, memory_byte_enable driven from registers for the whole state.
  - memory_we high only in cycle T+1, so a write commits exactly once.
  - A down-counter loaded with MEM_LATENCY-1; leave ACCESS when it reaches 0.
- RESP (cycle T+MEM_LATENCY+1):
  - The tagged port's resp_valid=1.
  - resp_data = memory_out for reads, 0 for writes; the other port's resp_valid=0.
  - A new grant may be made in this same cycle, giving back-to-back accesses.
  - Otherwise return to IDLE.
  - Throughput: one access per MEM_LATENCY+1 cycles.
- Outside ACCESS, memory_we=0 and memory_byte_enable=0; address and write data hold their last value.
- Priority (default build):
  - Data request wins over a simultaneous instruction request.
  - Starvation counter:
    - increments on each data grant while ireq_valid=1;
    - clears on any instruction grant, and whenever ireq_valid=0 at a grant.
  - When counter == STARVE_LIMIT, the instruction request wins the next arbitration.
  - Counter saturates and never wraps.
- Requesters must hold valid and payload stable until ready; the arbiter samples payload only in the accept cycle.
- Responses return in grant order; at most one access is outstanding.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN:
  - Defined: when both ports are valid, grant alternates based on a last-grant pointer, which updates on every grant; starvation counter not instantiated.
  - A single valid requester is always granted immediately.
  - Undefined: data-priority with STARVE_LIMIT as above.

Test Plan:
- Single fetch with MEM_LATENCY=1, memory word 0x00000013 at address 0x10:
  - ireq_valid with address 0x12 at cycle 0 -> ireq_ready at cycle 0; memory_address=0x10 at cycle 1; iresp_valid with iresp_data=0x00000013 at cycle 2.
- Data write, byte_enable 4'b0100, dreq_write 0x00AB0000, address 0x22:
  - memory_we high exactly one cycle with those values; dresp_valid with dresp_data=0 one cycle later; a subsequent read of 0x20 returns lane 2 = 0xAB.
- Both ports continuously valid, default build, STARVE_LIMIT=4:
  - grant order D,D,D,D,I,D,D,D,D,I; in RESP cycles a new grant is made in the same cycle, so no IDLE cycle occurs between accesses.
- Same stimulus with MEM_ARB_ROUND_ROBIN_EN:
  - grant order D,I,D,I… when the last grant before contention was I.
- MEM_LATENCY=3:
  - accept at cycle 0 -> resp_valid at cycle 4; ready low cycles 1–3; memory_we high only cycle 1.
- rst_n asserted at cycle T+1 of a pending read:
  - outputs 0 immediately (asynchronously); no resp_valid after release; next request is serviced normally.
